// File: rtl/led_dim_pwm_driver_if.sv
// Write port for the LED dimming driver: indexed brightness updates
// from the block statistics stage, with a frame-commit flag.
interface led_dim_pwm_driver_if #(
  parameter int DW = 8,
  parameter int IW = 6
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [IW-1:0] in_idx;
  logic          in_last;

  modport master (output in_valid, in_data, in_idx, in_last);
  modport slave  (input  in_valid, in_data, in_idx, in_last);
endinterface

// File: rtl/led_dim_pwm_driver.sv
// Double-buffered LED frame -> per-slot PWM -> LANES daisy-chained 74HC595 strings.
// Optional LED_IIR_EN: temporal smoothing of the front buffer on each swap.
module led_dim_pwm_driver #(
  parameter int N_LED    = 40,
  parameter int DW       = 8,
  parameter int LANES    = 6,
  parameter int SCLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  led_dim_pwm_driver_if.slave wr,
  output logic             shcp,
  output logic             stcp,
  output logic [LANES-1:0] ds,
  output logic             swap_pulse,
  output logic             err_idx
);
  localparam int L  = (N_LED + LANES - 1) / LANES;
  localparam int BW = (L > 1) ? $clog2(L) : 1;
  localparam int CW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DW-1:0] PMAX = DW'((64'd1 << DW) - 64'd2);

  typedef enum logic [1:0] {LOAD, SHIFT_LO, SHIFT_HI, LATCH} state_t;

  state_t                   st;
  logic [N_LED-1:0][DW-1:0] back, front, front_nxt;
  logic [LANES-1:0][L-1:0]  on_chain, on_q;
  logic [BW-1:0]            bidx;
  logic [CW-1:0]            cnt;
  logic [DW-1:0]            pcnt;
  logic                     pend;
  logic                     in_range, commit, last_cnt;

  assign in_range = (32'(wr.in_idx) < 32'(N_LED));
  assign commit   = wr.in_valid & wr.in_last;
  assign last_cnt = (cnt == CW'(SCLK_DIV - 1));

  // Chain slots beyond N_LED are padding and always shift 0.
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    for (genvar p = 0; p < L; p++) begin : g_pos
      localparam int K = j * L + p;
      if (K < N_LED) begin : g_led
        assign on_chain[j][p] = (front[K] > pcnt);
      end else begin : g_pad
        assign on_chain[j][p] = 1'b0;
      end
    end
  end

  for (genvar k = 0; k < N_LED; k++) begin : g_swap
`ifdef LED_IIR_EN
    logic [DW+1:0] f, b, diff, avg;
    assign f    = (DW+2)'(front[k]);
    assign b    = (DW+2)'(back[k]);
    assign diff = (b > f) ? (b - f) : (f - b);
    assign avg  = (f + (f << 1) + b + (DW+2)'(2)) >> 2;
    assign front_nxt[k] = (diff < (DW+2)'(4)) ? back[k] : avg[DW-1:0];
`else
    assign front_nxt[k] = back[k];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= LOAD;
      cnt        <= '0;
      bidx       <= '0;
      pcnt       <= '0;
      pend       <= 1'b0;
      shcp       <= 1'b0;
      stcp       <= 1'b0;
      ds         <= '0;
      swap_pulse <= 1'b0;
      err_idx    <= 1'b0;
      back       <= '0;
      front      <= '0;
      on_q       <= '0;
    end else begin
      swap_pulse <= 1'b0;
      if (wr.in_valid) begin
        if (in_range) back[wr.in_idx] <= wr.in_data;
        else          err_idx <= 1'b1;
      end
      if (commit) pend <= 1'b1;

      case (st)
        LOAD: begin
          on_q <= on_chain;
          bidx <= BW'(L - 1);
          for (int j = 0; j < LANES; j++) ds[j] <= on_chain[j][L-1];
          cnt  <= '0;
          st   <= SHIFT_LO;
        end
        SHIFT_LO: begin
          if (last_cnt) begin
            cnt  <= '0;
            shcp <= 1'b1;
            st   <= SHIFT_HI;
          end else cnt <= cnt + 1'b1;
        end
        SHIFT_HI: begin
          if (last_cnt) begin
            cnt  <= '0;
            shcp <= 1'b0;
            if (bidx == '0) begin
              stcp <= 1'b1;
              st   <= LATCH;
            end else begin
              bidx <= bidx - 1'b1;
              for (int j = 0; j < LANES; j++) ds[j] <= on_q[j][bidx - 1'b1];
              st   <= SHIFT_LO;
            end
          end else cnt <= cnt + 1'b1;
        end
        LATCH: begin
          if (last_cnt) begin
            cnt  <= '0;
            stcp <= 1'b0;
            st   <= LOAD;
            if (pcnt == PMAX) begin
              pcnt <= '0;
              // front_nxt reads back before this cycle's write lands;
              // a commit arriving on the swap cycle re-arms for the next wrap.
              if (pend) begin
                front      <= front_nxt;
                swap_pulse <= 1'b1;
                pend       <= commit;
              end
            end else pcnt <= pcnt + 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        default: st <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_led_dim_pwm_driver.sv
// Directed bench: models the external 595 chains and counts per-LED on-slots.
module tb_led_dim_pwm_driver;
  localparam int N_LED = 40, DW = 8, LANES = 6, SD = 2, L = 7, T = 31, P = 255;

  logic clk = 1'b0, rst = 1'b1;
  logic shcp, stcp, swap_pulse, err_idx;
  logic [LANES-1:0] ds;

  led_dim_pwm_driver_if #(.DW(DW), .IW(6)) wif ();

  led_dim_pwm_driver #(.N_LED(N_LED), .DW(DW), .LANES(LANES), .SCLK_DIV(SD)) dut (
    .clk(clk), .rst(rst), .wr(wif), .shcp(shcp), .stcp(stcp), .ds(ds),
    .swap_pulse(swap_pulse), .err_idx(err_idx)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // 595 chain model: index of sr equals chain position.
  logic [LANES-1:0][L-1:0] sr = '0;
  logic shcp_q = 1'b0, stcp_q = 1'b0;
  logic [LANES-1:0] ds_q = '0;
  int on_cnt[N_LED], on_lo[N_LED];
  int latches = 0, lat_idx = 0, swaps = 0, bad_stcp = 0, overlap = 0, bad_ds = 0;
  int run = 0, cyc = 0, last_rise = 0;
  logic have_prev = 1'b0;

  initial for (int k = 0; k < N_LED; k++) begin on_cnt[k] = 0; on_lo[k] = 0; end

  always @(negedge clk) begin
    cyc    <= cyc + 1;
    shcp_q <= shcp;
    stcp_q <= stcp;
    ds_q   <= ds;
    if (rst) begin
      lat_idx   <= 0;
      run       <= 0;
      have_prev <= 1'b0;
    end else begin
      if (shcp && !shcp_q)
        for (int j = 0; j < LANES; j++) sr[j] <= {sr[j][L-2:0], ds[j]};
      if (stcp && !stcp_q) begin
        for (int k = 0; k < N_LED; k++) if (sr[k / L][k % L]) begin
          on_cnt[k] <= on_cnt[k] + 1;
          if ((lat_idx % P) < 128) on_lo[k] <= on_lo[k] + 1;
        end
        if (have_prev && (cyc - last_rise) != T) bad_stcp <= bad_stcp + 1;
        have_prev <= 1'b1;
        last_rise <= cyc;
        lat_idx   <= lat_idx + 1;
        latches   <= latches + 1;
      end
      if (stcp) run <= run + 1;
      else if (stcp_q) begin
        if (run != SD) bad_stcp <= bad_stcp + 1;
        run <= 0;
      end
      if (stcp && shcp) overlap <= overlap + 1;
      if (ds != ds_q && shcp) bad_ds <= bad_ds + 1;
      if (swap_pulse) swaps <= swaps + 1;
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input int idx, input int data, input bit last);
    wif.in_valid = 1'b1;
    wif.in_idx   = 6'(idx);
    wif.in_data  = 8'(data);
    wif.in_last  = last;
    @(negedge clk);
    wif.in_valid = 1'b0;
    wif.in_last  = 1'b0;
  endtask

  task automatic wait_lat(input int n, input string tag);
    int tgt, i;
    tgt = latches + n;
    i = 0;
    while (latches < tgt && i < n * (T + 4) + 200) begin @(negedge clk); i++; end
    chk(tag, longint'(latches >= tgt), 1);
  endtask

  task automatic wait_swap(input string tag);
    int tgt, i;
    tgt = swaps + 1;
    i = 0;
    while (swaps < tgt && i < 2 * P * T + 400) begin @(negedge clk); i++; end
    chk(tag, longint'(swaps >= tgt), 1);
  endtask

  int s_cnt[N_LED], s_lo[N_LED];
  task automatic snap();
    for (int k = 0; k < N_LED; k++) begin s_cnt[k] = on_cnt[k]; s_lo[k] = on_lo[k]; end
  endtask

  function automatic int others_delta();
    int s = 0;
    for (int k = 1; k < N_LED - 1; k++) s += on_cnt[k] - s_cnt[k];
    return s;
  endfunction

  initial begin
    int sw0, lat0, i;
    wif.in_valid = 1'b0; wif.in_idx = '0; wif.in_data = '0; wif.in_last = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_shcp", shcp, 0);
    chk("rst_stcp", stcp, 0);
    chk("rst_ds", ds, 0);
    chk("rst_swap", swap_pulse, 0);
    chk("rst_err", err_idx, 0);
    rst = 1'b0;

    // Idle: nothing lit, latch shape regular, no swaps.
    snap();
    wait_lat(20, "idle_latches");
    chk("idle_on", others_delta() + on_cnt[0] + on_cnt[N_LED-1], 0);
    chk("idle_swaps", swaps, 0);
    chk("idle_stcp_shape", bad_stcp, 0);

    // Frame 1: LED0 full, LED39 half.
    wr(0, 255, 1'b0);
    wr(39, 128, 1'b1);
    chk("f1_err", err_idx, 0);
    wait_swap("f1_swap_seen");
    chk("f1_swap_at_wrap", lat_idx % P, 0);
    snap();
    wait_lat(P, "f1_period");
    chk("f1_led0_on", on_cnt[0] - s_cnt[0], 255);
    chk("f1_led39_on", on_cnt[39] - s_cnt[39], 128);
    chk("f1_led39_lo", on_lo[39] - s_lo[39], 128);
    chk("f1_others", others_delta(), 0);

    // Out-of-range write with commit: flagged, swap happens, frame unchanged.
    wr(40, 77, 1'b1);
    chk("oor_err_set", err_idx, 1);
    wait_swap("oor_swap_seen");
    snap();
    wait_lat(P, "oor_period");
    chk("oor_led0_on", on_cnt[0] - s_cnt[0], 255);
    chk("oor_led39_on", on_cnt[39] - s_cnt[39], 128);
    chk("oor_others", others_delta(), 0);
    chk("oor_err_sticky", err_idx, 1);

    // Two commits inside one period: one swap, second frame wins.
    i = 0;
    while ((lat_idx % P) != 5 && i < P * T + 200) begin @(negedge clk); i++; end
    chk("dbl_align", lat_idx % P, 5);
    sw0 = swaps;
    wr(39, 10, 1'b1);
    repeat (5) @(negedge clk);
    wr(39, 200, 1'b1);
    wait_swap("dbl_swap_seen");
    snap();
    wait_lat(P, "dbl_period");
    chk("dbl_one_swap", swaps - sw0, 1);
    chk("dbl_led39_on", on_cnt[39] - s_cnt[39], 200);
    chk("dbl_led39_lo", on_lo[39] - s_lo[39], 128);
    chk("dbl_led0_on", on_cnt[0] - s_cnt[0], 255);

    // Reset during SHIFT_HI with a 1 on the lines.
    i = 0;
    while (!(shcp === 1'b1 && ds !== '0) && i < 2 * T) begin @(negedge clk); i++; end
    chk("mid_found", longint'(shcp === 1'b1 && ds !== '0), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_shcp", shcp, 0);
    chk("mid_stcp", stcp, 0);
    chk("mid_ds", ds, 0);
    chk("mid_err_clr", err_idx, 0);
    lat0 = latches;
    rst = 1'b0;
    repeat (25) @(negedge clk);
    chk("mid_no_latch", latches - lat0, 0);

    chk("overlap", overlap, 0);
    chk("ds_stable_hi", bad_ds, 0);
    chk("stcp_shape", bad_stcp, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
